// File: rtl/i2s_rx_dsp_channel.sv
// DSP-mode (short frame-sync) I2S receiver: sync detect, bit offset, 1/2-line deserialiser, 2-entry holding register.
// Optional I2S_RX_SIGN_EXT_EN adds cfg_sign_ext_i for sign-extending received words.
module i2s_rx_dsp_channel (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        i2s_ch0_i,
    input  logic        i2s_ch1_i,
    input  logic        i2s_ws_i,
    output logic [31:0] fifo_data_o,
    output logic        fifo_data_valid_o,
    input  logic        fifo_data_ready_i,
    output logic        fifo_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_num_bits_i,
    input  logic [3:0]  cfg_num_word_i,
    input  logic        cfg_lsb_first_i,
    input  logic [8:0]  cfg_dsp_offset_i,
`ifdef I2S_RX_SIGN_EXT_EN
    input  logic        cfg_sign_ext_i,
`endif
    output logic [1:0]  dbg_state_o
);

    // Handshake: a word transfers on every sck_i edge where fifo_data_valid_o and
    // fifo_data_ready_i are both high; data is held stable while valid=1 and ready=0.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WS = 2'd1,
        OFFSET  = 2'd2,
        RUN     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  off_cnt_q, off_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic [31:0] sh0_q, sh0_d;
    logic [31:0] sh1_q, sh1_d;
    logic [31:0] h0_q, h0_d;
    logic [31:0] h1_q, h1_d;
    logic        h0_v_q, h0_v_d;
    logic        h1_v_q, h1_v_d;
    logic        err_q, err_d;

    logic        last_bit;
    logic        last_word;
    logic        word_done;
    logic        sync_err;
    logic        overflow;
    logic        sign0;
    logic        sign1;
    logic [31:0] upper_mask;
    logic [31:0] sh0_next;
    logic [31:0] sh1_next;
    logic [31:0] word0;
    logic [31:0] word1;
    state_e      start_state;

    assign last_bit    = (bit_cnt_q == cfg_num_bits_i);
    assign last_word   = (word_cnt_q == cfg_num_word_i);
    assign start_state = (cfg_dsp_offset_i == 9'd0) ? RUN : OFFSET;
    assign upper_mask  = 32'hFFFF_FFFE << cfg_num_bits_i;

    always_comb begin
        sh0_next = 32'd0;
        sh1_next = 32'd0;
        if (cfg_lsb_first_i) begin
            sh0_next = sh0_q | ({31'd0, i2s_ch0_i} << bit_cnt_q);
            sh1_next = sh1_q | ({31'd0, i2s_ch1_i} << bit_cnt_q);
        end else begin
            sh0_next = {sh0_q[30:0], i2s_ch0_i};
            sh1_next = {sh1_q[30:0], i2s_ch1_i};
        end
    end

    // Bits above the word width are forced to zero, then optionally filled with the sign bit.
    always_comb begin
        sign0 = 1'b0;
        sign1 = 1'b0;
`ifdef I2S_RX_SIGN_EXT_EN
        sign0 = cfg_sign_ext_i & sh0_next[cfg_num_bits_i];
        sign1 = cfg_sign_ext_i & sh1_next[cfg_num_bits_i];
`endif
        word0 = sign0 ? (sh0_next | upper_mask) : (sh0_next & ~upper_mask);
        word1 = sign1 ? (sh1_next | upper_mask) : (sh1_next & ~upper_mask);
    end

    always_comb begin
        state_d    = state_q;
        off_cnt_d  = off_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        h0_v_d     = h0_v_q;
        h1_v_d     = h1_v_q;
        word_done  = 1'b0;
        sync_err   = 1'b0;
        overflow   = 1'b0;

        if (fifo_data_valid_o && fifo_data_ready_i) begin
            if (h0_v_q) h0_v_d = 1'b0;
            else        h1_v_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_en_i) state_d = WAIT_WS;
            end
            WAIT_WS: begin
                if (i2s_ws_i) begin
                    state_d    = start_state;
                    off_cnt_d  = 9'd0;
                    bit_cnt_d  = 5'd0;
                    word_cnt_d = 4'd0;
                    sh0_d      = 32'd0;
                    sh1_d      = 32'd0;
                end
            end
            OFFSET: begin
                if (i2s_ws_i) begin
                    sync_err  = 1'b1;
                    off_cnt_d = 9'd0;
                end else if (off_cnt_q + 9'd1 == cfg_dsp_offset_i) begin
                    state_d   = RUN;
                    off_cnt_d = 9'd0;
                end else begin
                    off_cnt_d = off_cnt_q + 9'd1;
                end
            end
            RUN: begin
                if (i2s_ws_i && !(last_bit && last_word)) begin
                    // Resync: the partial word is dropped and the frame restarts from this pulse.
                    sync_err   = 1'b1;
                    state_d    = start_state;
                    off_cnt_d  = 9'd0;
                    bit_cnt_d  = 5'd0;
                    word_cnt_d = 4'd0;
                    sh0_d      = 32'd0;
                    sh1_d      = 32'd0;
                end else if (last_bit) begin
                    word_done = 1'b1;
                    bit_cnt_d = 5'd0;
                    sh0_d     = 32'd0;
                    sh1_d     = 32'd0;
                    if (last_word) begin
                        word_cnt_d = 4'd0;
                        off_cnt_d  = 9'd0;
                        state_d    = i2s_ws_i ? start_state : WAIT_WS;
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                    end
                end else begin
                    sh0_d     = sh0_next;
                    sh1_d     = sh1_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Occupancy is judged on the registered entries, so a pop on the completion edge still overflows.
        if (word_done) begin
            if (h0_v_q || h1_v_q) begin
                overflow = 1'b1;
            end else begin
                h0_d   = word0;
                h0_v_d = 1'b1;
                if (cfg_2ch_i) begin
                    h1_d   = word1;
                    h1_v_d = 1'b1;
                end
            end
        end

        err_d = overflow | sync_err;

        if (!cfg_en_i) begin
            state_d    = IDLE;
            off_cnt_d  = 9'd0;
            bit_cnt_d  = 5'd0;
            word_cnt_d = 4'd0;
            sh0_d      = 32'd0;
            sh1_d      = 32'd0;
            h0_d       = 32'd0;
            h1_d       = 32'd0;
            h0_v_d     = 1'b0;
            h1_v_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            off_cnt_q  <= 9'd0;
            bit_cnt_q  <= 5'd0;
            word_cnt_q <= 4'd0;
            sh0_q      <= 32'd0;
            sh1_q      <= 32'd0;
            h0_q       <= 32'd0;
            h1_q       <= 32'd0;
            h0_v_q     <= 1'b0;
            h1_v_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_cnt_q  <= off_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            h0_v_q     <= h0_v_d;
            h1_v_q     <= h1_v_d;
            err_q      <= err_d;
        end
    end

    assign fifo_data_valid_o = h0_v_q | h1_v_q;
    assign fifo_data_o       = h0_v_q ? h0_q : h1_q;
    assign fifo_err_o        = err_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Directed bench for i2s_rx_dsp_channel; sign-extension scenario built only with I2S_RX_SIGN_EXT_EN.
module tb_i2s_rx_dsp_channel;

    logic        sck_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        i2s_ch0_i = 1'b0;
    logic        i2s_ch1_i = 1'b0;
    logic        i2s_ws_i = 1'b0;
    logic [31:0] fifo_data_o;
    logic        fifo_data_valid_o;
    logic        fifo_data_ready_i = 1'b1;
    logic        fifo_err_o;
    logic        cfg_en_i = 1'b0;
    logic        cfg_2ch_i = 1'b0;
    logic [4:0]  cfg_num_bits_i = 5'd15;
    logic [3:0]  cfg_num_word_i = 4'd0;
    logic        cfg_lsb_first_i = 1'b0;
    logic [8:0]  cfg_dsp_offset_i = 9'd0;
`ifdef I2S_RX_SIGN_EXT_EN
    logic        cfg_sign_ext_i = 1'b0;
`endif
    logic [1:0]  dbg_state_o;

    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_OFF = 2'd2, S_RUN = 2'd3;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int err_seen = 0;
    logic [31:0] got_q[$];

    i2s_rx_dsp_channel dut (
        .sck_i             (sck_i),
        .rstn_i            (rstn_i),
        .i2s_ch0_i         (i2s_ch0_i),
        .i2s_ch1_i         (i2s_ch1_i),
        .i2s_ws_i          (i2s_ws_i),
        .fifo_data_o       (fifo_data_o),
        .fifo_data_valid_o (fifo_data_valid_o),
        .fifo_data_ready_i (fifo_data_ready_i),
        .fifo_err_o        (fifo_err_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_2ch_i         (cfg_2ch_i),
        .cfg_num_bits_i    (cfg_num_bits_i),
        .cfg_num_word_i    (cfg_num_word_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i),
        .cfg_dsp_offset_i  (cfg_dsp_offset_i),
`ifdef I2S_RX_SIGN_EXT_EN
        .cfg_sign_ext_i    (cfg_sign_ext_i),
`endif
        .dbg_state_o       (dbg_state_o)
    );

    // clock / reset
    always #5 sck_i = ~sck_i;

    // scoreboard capture: every accepted word and every error pulse
    always @(posedge sck_i) begin
        if (rstn_i && fifo_data_valid_o && fifo_data_ready_i) got_q.push_back(fifo_data_o);
        if (rstn_i && fifo_err_o) err_seen++;
    end

    task automatic cycle();
        @(posedge sck_i);
        #1;
    endtask

    task automatic apply_cfg(input logic two, input logic [4:0] nb, input logic [3:0] nw,
                             input logic lsb, input logic [8:0] off, input logic rdy);
        cfg_en_i = 1'b0;
        i2s_ws_i = 1'b0;
        i2s_ch0_i = 1'b0;
        i2s_ch1_i = 1'b0;
        cycle();
        cfg_2ch_i = two;
        cfg_num_bits_i = nb;
        cfg_num_word_i = nw;
        cfg_lsb_first_i = lsb;
        cfg_dsp_offset_i = off;
        fifo_data_ready_i = rdy;
        cfg_en_i = 1'b1;
        cycle();
    endtask

    // drives one word; ws is raised during bit position ws_at (-1 = never)
    task automatic drive_bits(input logic [31:0] d0, input logic [31:0] d1, input int nbits,
                              input logic lsb, input int ws_at);
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = lsb ? i : (nbits - 1 - i);
            i2s_ch0_i = d0[idx];
            i2s_ch1_i = d1[idx];
            i2s_ws_i  = (i == ws_at);
            cycle();
        end
        i2s_ws_i = 1'b0;
    endtask

    task automatic sync_pulse();
        i2s_ws_i = 1'b1;
        cycle();
        i2s_ws_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        cycle();
        cycle();
        chk_cnt++; if (fifo_data_o !== 32'd0) $display("FAIL reset_data got=%h exp=%h", fifo_data_o, 32'd0); else pass_cnt++;
        chk_cnt++; if (fifo_data_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fifo_data_valid_o); else pass_cnt++;
        chk_cnt++; if (fifo_err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", fifo_err_o); else pass_cnt++;
        chk_cnt++; if (dbg_state_o !== S_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, S_IDLE); else pass_cnt++;
        rstn_i = 1'b1;
        cycle();
    endtask

    task automatic test_1ch_msb();
        logic [15:0] w;
        int base;
        int eb;
        apply_cfg(1'b0, 5'd15, 4'd1, 1'b0, 9'd0, 1'b1);
        base = got_q.size();
        eb = err_seen;
        sync_pulse();
        chk_cnt++; if (dbg_state_o !== S_RUN) $display("FAIL msb_state_run got=%0d exp=%0d", dbg_state_o, S_RUN); else pass_cnt++;
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            i2s_ch0_i = w[15 - i];
            cycle();
            if (i == 14) begin
                chk_cnt++; if (fifo_data_valid_o !== 1'b0) $display("FAIL msb_valid_early got=%b exp=0", fifo_data_valid_o); else pass_cnt++;
            end
        end
        chk_cnt++; if (fifo_data_valid_o !== 1'b1) $display("FAIL msb_valid_edge16 got=%b exp=1", fifo_data_valid_o); else pass_cnt++;
        chk_cnt++; if (fifo_data_o !== 32'h0000A5C3) $display("FAIL msb_word0 got=%h exp=%h", fifo_data_o, 32'h0000A5C3); else pass_cnt++;
        drive_bits(32'h1234, 32'h0, 16, 1'b0, -1);
        chk_cnt++; if (fifo_data_o !== 32'h00001234) $display("FAIL msb_word1 got=%h exp=%h", fifo_data_o, 32'h00001234); else pass_cnt++;
        cycle();
        cycle();
        chk_cnt++; if (got_q.size() - base !== 2) $display("FAIL msb_count got=%0d exp=2", got_q.size() - base); else pass_cnt++;
        chk_cnt++; if (got_q[base + 1] !== 32'h00001234) $display("FAIL msb_sb_word1 got=%h exp=%h", got_q[base + 1], 32'h00001234); else pass_cnt++;
        chk_cnt++; if (dbg_state_o !== S_WAIT) $display("FAIL msb_state_end got=%0d exp=%0d", dbg_state_o, S_WAIT); else pass_cnt++;
        chk_cnt++; if (err_seen - eb !== 0) $display("FAIL msb_no_err got=%0d exp=0", err_seen - eb); else pass_cnt++;
    endtask

    task automatic test_2ch_lsb_offset();
        int base;
        apply_cfg(1'b1, 5'd7, 4'd0, 1'b1, 9'd3, 1'b1);
        base = got_q.size();
        sync_pulse();
        i2s_ch0_i = 1'b1;
        i2s_ch1_i = 1'b1;
        cycle();
        chk_cnt++; if (dbg_state_o !== S_OFF) $display("FAIL off_state_t1 got=%0d exp=%0d", dbg_state_o, S_OFF); else pass_cnt++;
        cycle();
        chk_cnt++; if (dbg_state_o !== S_OFF) $display("FAIL off_state_t2 got=%0d exp=%0d", dbg_state_o, S_OFF); else pass_cnt++;
        cycle();
        chk_cnt++; if (dbg_state_o !== S_RUN) $display("FAIL off_state_t3 got=%0d exp=%0d", dbg_state_o, S_RUN); else pass_cnt++;
        drive_bits(32'h5A, 32'hC3, 8, 1'b1, -1);
        chk_cnt++; if (fifo_data_o !== 32'h0000005A || fifo_data_valid_o !== 1'b1)
            $display("FAIL two_ch_word0 got=%h/%b exp=%h/1", fifo_data_o, fifo_data_valid_o, 32'h5A); else pass_cnt++;
        cycle();
        chk_cnt++; if (fifo_data_o !== 32'h000000C3 || fifo_data_valid_o !== 1'b1)
            $display("FAIL two_ch_word1 got=%h/%b exp=%h/1", fifo_data_o, fifo_data_valid_o, 32'hC3); else pass_cnt++;
        cycle();
        chk_cnt++; if (fifo_data_valid_o !== 1'b0) $display("FAIL two_ch_drained got=%b exp=0", fifo_data_valid_o); else pass_cnt++;
        chk_cnt++; if (got_q.size() - base !== 2 || got_q[base] !== 32'h5A)
            $display("FAIL two_ch_sb got=%0d/%h exp=2/%h", got_q.size() - base, got_q[base], 32'h5A); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int base;
        int eb;
        apply_cfg(1'b0, 5'd7, 4'd1, 1'b0, 9'd0, 1'b0);
        base = got_q.size();
        eb = err_seen;
        sync_pulse();
        drive_bits(32'h3C, 32'h0, 8, 1'b0, -1);
        chk_cnt++; if (fifo_data_o !== 32'h3C || fifo_data_valid_o !== 1'b1)
            $display("FAIL ovf_first got=%h/%b exp=%h/1", fifo_data_o, fifo_data_valid_o, 32'h3C); else pass_cnt++;
        drive_bits(32'h96, 32'h0, 8, 1'b0, -1);
        chk_cnt++; if (fifo_err_o !== 1'b1) $display("FAIL ovf_err_pulse got=%b exp=1", fifo_err_o); else pass_cnt++;
        chk_cnt++; if (fifo_data_o !== 32'h3C) $display("FAIL ovf_held got=%h exp=%h", fifo_data_o, 32'h3C); else pass_cnt++;
        cycle();
        chk_cnt++; if (fifo_err_o !== 1'b0) $display("FAIL ovf_err_width got=%b exp=0", fifo_err_o); else pass_cnt++;
        fifo_data_ready_i = 1'b1;
        cycle();
        chk_cnt++; if (fifo_data_valid_o !== 1'b0) $display("FAIL ovf_drain got=%b exp=0", fifo_data_valid_o); else pass_cnt++;
        cycle();
        chk_cnt++; if (got_q.size() - base !== 1 || got_q[base] !== 32'h3C)
            $display("FAIL ovf_sb got=%0d/%h exp=1/%h", got_q.size() - base, got_q[base], 32'h3C); else pass_cnt++;
        chk_cnt++; if (err_seen - eb !== 1) $display("FAIL ovf_err_count got=%0d exp=1", err_seen - eb); else pass_cnt++;
    endtask

    task automatic test_sync_err();
        int base;
        int eb;
        logic [7:0] part;
        apply_cfg(1'b0, 5'd7, 4'd1, 1'b0, 9'd0, 1'b1);
        base = got_q.size();
        eb = err_seen;
        sync_pulse();
        drive_bits(32'h11, 32'h0, 8, 1'b0, -1);
        part = 8'h2B;
        for (int i = 0; i < 5; i++) begin
            i2s_ch0_i = part[7 - i];
            cycle();
        end
        sync_pulse();
        chk_cnt++; if (fifo_err_o !== 1'b1) $display("FAIL sync_err_pulse got=%b exp=1", fifo_err_o); else pass_cnt++;
        chk_cnt++; if (dbg_state_o !== S_RUN) $display("FAIL sync_resync_state got=%0d exp=%0d", dbg_state_o, S_RUN); else pass_cnt++;
        drive_bits(32'hE7, 32'h0, 8, 1'b0, -1);
        drive_bits(32'h42, 32'h0, 8, 1'b0, -1);
        cycle();
        chk_cnt++; if (got_q.size() - base !== 3) $display("FAIL sync_count got=%0d exp=3", got_q.size() - base); else pass_cnt++;
        chk_cnt++; if (got_q[base + 1] !== 32'hE7) $display("FAIL sync_aligned got=%h exp=%h", got_q[base + 1], 32'hE7); else pass_cnt++;
        chk_cnt++; if (got_q[base + 2] !== 32'h42) $display("FAIL sync_next got=%h exp=%h", got_q[base + 2], 32'h42); else pass_cnt++;
        chk_cnt++; if (err_seen - eb !== 1) $display("FAIL sync_err_count got=%0d exp=1", err_seen - eb); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base;
        int eb;
        apply_cfg(1'b0, 5'd7, 4'd0, 1'b0, 9'd0, 1'b1);
        base = got_q.size();
        eb = err_seen;
        sync_pulse();
        drive_bits(32'hA1, 32'h0, 8, 1'b0, 7);
        chk_cnt++; if (fifo_data_o !== 32'hA1 || dbg_state_o !== S_RUN)
            $display("FAIL b2b_first got=%h/%0d exp=%h/%0d", fifo_data_o, dbg_state_o, 32'hA1, S_RUN); else pass_cnt++;
        drive_bits(32'hB2, 32'h0, 8, 1'b0, 7);
        chk_cnt++; if (fifo_data_o !== 32'hB2) $display("FAIL b2b_second got=%h exp=%h", fifo_data_o, 32'hB2); else pass_cnt++;
        drive_bits(32'hC3, 32'h0, 8, 1'b0, -1);
        chk_cnt++; if (fifo_data_o !== 32'hC3) $display("FAIL b2b_third got=%h exp=%h", fifo_data_o, 32'hC3); else pass_cnt++;
        cycle();
        chk_cnt++; if (dbg_state_o !== S_WAIT) $display("FAIL b2b_state got=%0d exp=%0d", dbg_state_o, S_WAIT); else pass_cnt++;
        chk_cnt++; if (got_q.size() - base !== 3) $display("FAIL b2b_count got=%0d exp=3", got_q.size() - base); else pass_cnt++;
        chk_cnt++; if (err_seen - eb !== 0) $display("FAIL b2b_no_err got=%0d exp=0", err_seen - eb); else pass_cnt++;

        apply_cfg(1'b0, 5'd7, 4'd1, 1'b0, 9'd0, 1'b0);
        sync_pulse();
        drive_bits(32'h5F, 32'h0, 8, 1'b0, -1);
        chk_cnt++; if (fifo_data_valid_o !== 1'b1) $display("FAIL dis_pending got=%b exp=1", fifo_data_valid_o); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            i2s_ch0_i = i[0];
            cycle();
        end
        cfg_en_i = 1'b0;
        cycle();
        chk_cnt++; if (fifo_data_valid_o !== 1'b0) $display("FAIL dis_valid got=%b exp=0", fifo_data_valid_o); else pass_cnt++;
        chk_cnt++; if (dbg_state_o !== S_IDLE) $display("FAIL dis_state got=%0d exp=%0d", dbg_state_o, S_IDLE); else pass_cnt++;
        fifo_data_ready_i = 1'b1;
    endtask

`ifdef I2S_RX_SIGN_EXT_EN
    task automatic test_sign_ext();
        cfg_en_i = 1'b0;
        cycle();
        cfg_sign_ext_i = 1'b1;
        apply_cfg(1'b0, 5'd11, 4'd0, 1'b0, 9'd0, 1'b1);
        sync_pulse();
        drive_bits(32'h800, 32'h0, 12, 1'b0, -1);
        chk_cnt++; if (fifo_data_o !== 32'hFFFFF800) $display("FAIL sext_on got=%h exp=%h", fifo_data_o, 32'hFFFFF800); else pass_cnt++;
        cfg_en_i = 1'b0;
        cycle();
        cfg_sign_ext_i = 1'b0;
        apply_cfg(1'b0, 5'd11, 4'd0, 1'b0, 9'd0, 1'b1);
        sync_pulse();
        drive_bits(32'h800, 32'h0, 12, 1'b0, -1);
        chk_cnt++; if (fifo_data_o !== 32'h00000800) $display("FAIL sext_off got=%h exp=%h", fifo_data_o, 32'h00000800); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_1ch_msb();
        test_2ch_lsb_offset();
        test_overflow();
        test_sync_err();
        test_back_to_back();
`ifdef I2S_RX_SIGN_EXT_EN
        test_sign_ext();
`endif
        cycle();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
